// File: rtl/vga_console_ctrl.sv
// vga_console_ctrl
// Text-console front end. It takes ASCII characters over a valid/ready
// handshake and turns them into writes to a text buffer of COLS x ROWS cells.
// A form feed, and every reset release, clears the whole screen by writing a
// space to each cell in turn.
//
// Parameters:
//   COLS, ROWS  - text columns per row / text rows per screen
//   ADDR_WIDTH  - text-buffer address width (>= clog2(COLS*ROWS))
// Ports:
//   clk, reset              - rising-edge clock, async active-high reset
//   char_valid/char_data    - producer offers an ASCII code
//   char_ready              - character accepted this cycle (IDLE only)
//   buf_addr/buf_data/buf_we- registered text-buffer write port
//   cursor_col/cursor_row   - current cursor position
//   busy                    - screen clear in progress
// Configuration macro: CONSOLE_WRAP_EN
//   defined   -> a row advance on the last row wraps to row 0
//   undefined -> the row saturates on the last row, which is then overwritten
module vga_console_ctrl #(
  parameter int COLS       = 80,
  parameter int ROWS       = 30,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    char_valid,
  input  logic [7:0]              char_data,
  output logic                    char_ready,
  output logic [ADDR_WIDTH-1:0]   buf_addr,
  output logic [7:0]              buf_data,
  output logic                    buf_we,
  output logic [$clog2(COLS)-1:0] cursor_col,
  output logic [$clog2(ROWS)-1:0] cursor_row,
  output logic                    busy
);

  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);
  localparam logic [ADDR_WIDTH-1:0] LAST_CELL = ADDR_WIDTH'(COLS * ROWS - 1);
  localparam logic [COL_W-1:0]      LAST_COL  = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]      LAST_ROW  = ROW_W'(ROWS - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t                  r_state;
  logic [COL_W-1:0]        r_col;
  logic [ROW_W-1:0]        r_row;
  logic [ADDR_WIDTH-1:0]   r_cnt;
  logic [ADDR_WIDTH-1:0]   r_buf_addr;
  logic [7:0]              r_buf_data;
  logic                    r_buf_we;

  logic [ADDR_WIDTH-1:0]   w_cell_addr;
  logic                    w_printable;

  assign w_cell_addr = ADDR_WIDTH'(r_row) * ADDR_WIDTH'(COLS) + ADDR_WIDTH'(r_col);
  assign w_printable = (char_data >= 8'h20) && (char_data <= 8'h7E);

  // Row advance; behaviour on the last row is the only build-time difference.
  function automatic logic [ROW_W-1:0] next_row(input logic [ROW_W-1:0] row);
    if (row == LAST_ROW) begin
`ifdef CONSOLE_WRAP_EN
      next_row = '0;
`else
      next_row = row;
`endif
    end else begin
      next_row = row + ROW_W'(1);
    end
  endfunction

  // Control FSM, cursor and registered buffer write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_CLEAR;
      r_cnt      <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_buf_we   <= 1'b0;
      r_buf_addr <= '0;
      r_buf_data <= 8'h00;
    end else begin
      // Write strobe is a single-cycle pulse; addr/data hold otherwise.
      r_buf_we <= 1'b0;
      case (r_state)
        S_CLEAR: begin
          r_buf_we   <= 1'b1;
          r_buf_addr <= r_cnt;
          r_buf_data <= 8'h20;
          if (r_cnt == LAST_CELL) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_col   <= '0;
            r_row   <= '0;
          end else begin
            r_cnt <= r_cnt + ADDR_WIDTH'(1);
          end
        end
        S_IDLE: begin
          if (char_valid) begin
            case (char_data)
              8'h0A: begin
                r_col <= '0;
                r_row <= next_row(r_row);
              end
              8'h0D: begin
                r_col <= '0;
              end
              8'h08: begin
                // Erase the cell left of the cursor; nothing at column 0.
                if (r_col != '0) begin
                  r_col      <= r_col - COL_W'(1);
                  r_buf_we   <= 1'b1;
                  r_buf_addr <= w_cell_addr - ADDR_WIDTH'(1);
                  r_buf_data <= 8'h20;
                end else begin
                  r_col <= r_col;
                end
              end
              8'h0C: begin
                // Cursor keeps its place until the clear finishes.
                r_state <= S_CLEAR;
                r_cnt   <= '0;
              end
              default: begin
                if (w_printable) begin
                  r_buf_we   <= 1'b1;
                  r_buf_addr <= w_cell_addr;
                  r_buf_data <= char_data;
                  if (r_col == LAST_COL) begin
                    r_col <= '0;
                    r_row <= next_row(r_row);
                  end else begin
                    r_col <= r_col + COL_W'(1);
                  end
                end else begin
                  r_col <= r_col;
                end
              end
            endcase
          end else begin
            r_col <= r_col;
          end
        end
        default: begin
          r_state <= S_CLEAR;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign char_ready = (r_state == S_IDLE);
  assign busy       = (r_state == S_CLEAR);
  assign buf_we     = r_buf_we;
  assign buf_addr   = r_buf_addr;
  assign buf_data   = r_buf_data;
  assign cursor_col = r_col;
  assign cursor_row = r_row;

endmodule

// File: tb/tb_vga_console_ctrl.sv
// Testbench for vga_console_ctrl (COLS=80, ROWS=30, ADDR_WIDTH=12).
// A behavioural screen model tracks the expected cursor, mode and write port
// as plain integers and is compared with the DUT each cycle.
module tb_vga_console_ctrl;

  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int AW    = 12;
  localparam int CELLS = COLS * ROWS;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          char_valid = 1'b0;
  logic [7:0]    char_data = 8'h00;
  logic          char_ready;
  logic [AW-1:0] buf_addr;
  logic [7:0]    buf_data;
  logic          buf_we;
  logic [6:0]    cursor_col;
  logic [4:0]    cursor_row;
  logic          busy;

  vga_console_ctrl #(.COLS(COLS), .ROWS(ROWS), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .char_valid(char_valid), .char_data(char_data),
    .char_ready(char_ready), .buf_addr(buf_addr), .buf_data(buf_data),
    .buf_we(buf_we), .cursor_col(cursor_col), .cursor_row(cursor_row),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  bit m_idle;
  int m_col, m_row, m_cnt;
  bit m_we;
  int m_addr, m_data;

  wire [34:0] w_obs = {buf_we, buf_addr, buf_data, char_ready, busy, cursor_col, cursor_row};

  function automatic logic [34:0] exp_vec();
    return {m_we, AW'(m_addr), 8'(m_data), m_idle, ~m_idle, 7'(m_col), 5'(m_row)};
  endfunction

  function automatic void model_reset();
    m_idle = 1'b0; m_cnt = 0; m_col = 0; m_row = 0;
    m_we = 1'b0; m_addr = 0; m_data = 0;
  endfunction

  function automatic void row_adv();
    if (m_row < ROWS - 1) m_row++;
    else begin
`ifdef CONSOLE_WRAP_EN
      m_row = 0;
`else
      m_row = ROWS - 1;
`endif
    end
  endfunction

  // One clock edge of the screen behaviour.
  function automatic void model_edge(input bit v, input logic [7:0] c);
    m_we = 1'b0;
    if (!m_idle) begin
      m_we = 1'b1; m_addr = m_cnt; m_data = 32;
      if (m_cnt == CELLS - 1) begin
        m_idle = 1'b1; m_cnt = 0; m_col = 0; m_row = 0;
      end else m_cnt++;
    end else if (v) begin
      if (c >= 8'h20 && c <= 8'h7E) begin
        m_we = 1'b1; m_addr = m_row * COLS + m_col; m_data = int'(c);
        if (m_col == COLS - 1) begin m_col = 0; row_adv(); end
        else m_col++;
      end else if (c == 8'h0A) begin
        m_col = 0; row_adv();
      end else if (c == 8'h0D) begin
        m_col = 0;
      end else if (c == 8'h08) begin
        if (m_col > 0) begin
          m_col--; m_we = 1'b1; m_addr = m_row * COLS + m_col; m_data = 32;
        end
      end else if (c == 8'h0C) begin
        m_idle = 1'b0; m_cnt = 0;
      end
    end
  endfunction

  task automatic step(input bit v, input logic [7:0] c);
    char_valid = v;
    char_data  = c;
    @(posedge clk);
    model_edge(v, c);
    #1;
    char_valid = 1'b0;
    char_data  = 8'($urandom);
  endtask

  function automatic logic [7:0] rand_char();
    logic [7:0] v;
    case ($urandom_range(0, 9))
      0: v = 8'h0A;
      1: v = 8'h0D;
      2: v = 8'h08;
      3: begin
        v = 8'($urandom_range(0, 31));
        if (v == 8'h08 || v == 8'h0A || v == 8'h0C || v == 8'h0D) v = 8'h1B;
      end
      4: v = 8'($urandom_range(127, 255));
      default: v = 8'($urandom_range(32, 126));
    endcase
    return v;
  endfunction

  task automatic test_reset();
    #2 reset = 1'b1;
    model_reset();
    #1;
    if (w_obs !== exp_vec()) begin
      n_err++; $display("FAIL reset_async: got %h want %h", w_obs, exp_vec());
    end
    n_vec++;
    repeat (3) @(posedge clk);
    #1;
    if (w_obs !== exp_vec()) begin
      n_err++; $display("FAIL reset_hold: got %h want %h", w_obs, exp_vec());
    end
    n_vec++;
    reset = 1'b0;
    for (int i = 0; i < CELLS; i++) begin
      step(1'($urandom_range(0, 1)), 8'h41);
      if (w_obs !== exp_vec()) begin
        n_err++; $display("FAIL clear_after_reset %0d: got %h want %h", i, w_obs, exp_vec());
      end
      n_vec++;
    end
    if ({char_ready, busy, cursor_col, cursor_row, buf_addr} !== {1'b1, 1'b0, 7'd0, 5'd0, 12'd2399}) begin
      n_err++; $display("FAIL ready_after_clear: got %b/%0d/%0d/%0d", char_ready, cursor_col, cursor_row, buf_addr);
    end
    n_vec++;
  endtask

  task automatic test_print_one();
    step(1'b1, 8'h41);
    if (w_obs !== exp_vec()) begin
      n_err++; $display("FAIL print_one_model: got %h want %h", w_obs, exp_vec());
    end
    n_vec++;
    if ({buf_we, buf_addr, buf_data, cursor_col} !== {1'b1, 12'd0, 8'h41, 7'd1}) begin
      n_err++; $display("FAIL print_one: got we=%b addr=%0d data=%h col=%0d want 1/0/41/1", buf_we, buf_addr, buf_data, cursor_col);
    end
    n_vec++;
  endtask

  task automatic test_back_to_back();
    step(1'b1, 8'h0D);
    if (w_obs !== exp_vec()) begin
      n_err++; $display("FAIL b2b_cr: got %h want %h", w_obs, exp_vec());
    end
    n_vec++;
    for (int i = 0; i < COLS; i++) begin
      step(1'b1, 8'h58);
      if (w_obs !== exp_vec() || buf_addr !== AW'(i) || buf_we !== 1'b1) begin
        n_err++; $display("FAIL b2b_write %0d: got %h want %h", i, w_obs, exp_vec());
      end
      n_vec++;
    end
    if ({cursor_col, cursor_row} !== {7'd0, 5'd1}) begin
      n_err++; $display("FAIL b2b_cursor: got (%0d,%0d) want (0,1)", cursor_col, cursor_row);
    end
    n_vec++;
    step(1'b0, 8'h58);
    if (w_obs !== exp_vec()) begin
      n_err++; $display("FAIL b2b_idle_hold: got %h want %h", w_obs, exp_vec());
    end
    n_vec++;
  endtask

  task automatic test_backspace();
    step(1'b1, 8'h0C);
    if (w_obs !== exp_vec() || buf_we !== 1'b0) begin
      n_err++; $display("FAIL ff_accept: got %h want %h", w_obs, exp_vec());
    end
    n_vec++;
    for (int i = 0; i < CELLS; i++) begin
      step(1'b0, 8'h00);
      if (w_obs !== exp_vec()) begin
        n_err++; $display("FAIL ff_clear %0d: got %h want %h", i, w_obs, exp_vec());
      end
      n_vec++;
    end
    step(1'b1, 8'h08);
    if (w_obs !== exp_vec() || buf_we !== 1'b0) begin
      n_err++; $display("FAIL bs_col0: got %h want %h", w_obs, exp_vec());
    end
    n_vec++;
    step(1'b1, 8'h41);
    step(1'b1, 8'h42);
    if (w_obs !== exp_vec()) begin
      n_err++; $display("FAIL bs_ab: got %h want %h", w_obs, exp_vec());
    end
    n_vec++;
    step(1'b1, 8'h08);
    if ({buf_we, buf_addr, buf_data, cursor_col} !== {1'b1, 12'd1, 8'h20, 7'd1} || w_obs !== exp_vec()) begin
      n_err++; $display("FAIL bs_erase: got we=%b addr=%0d data=%h col=%0d want 1/1/20/1", buf_we, buf_addr, buf_data, cursor_col);
    end
    n_vec++;
  endtask

  task automatic test_row_limit();
    int exp_row;
`ifdef CONSOLE_WRAP_EN
    exp_row = 0;
`else
    exp_row = ROWS - 1;
`endif
    for (int i = 0; i < ROWS - 1; i++) begin
      step(1'b1, 8'h0A);
      if (w_obs !== exp_vec()) begin
        n_err++; $display("FAIL lf_walk %0d: got %h want %h", i, w_obs, exp_vec());
      end
      n_vec++;
    end
    if ({cursor_col, cursor_row} !== {7'd0, 5'd29}) begin
      n_err++; $display("FAIL lf_row29: got (%0d,%0d) want (0,29)", cursor_col, cursor_row);
    end
    n_vec++;
    step(1'b1, 8'h5A);
    step(1'b1, 8'h0A);
    if (cursor_col !== 7'd0 || cursor_row !== 5'(exp_row) || w_obs !== exp_vec()) begin
      n_err++; $display("FAIL lf_last_row: got (%0d,%0d) want (0,%0d)", cursor_col, cursor_row, exp_row);
    end
    n_vec++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), rand_char());
      if (w_obs !== exp_vec()) begin
        n_err++; $display("FAIL random %0d: got %h want %h", i, w_obs, exp_vec());
      end
      n_vec++;
    end
  endtask

  task automatic test_reset_mid_clear();
    step(1'b1, 8'h0C);
    for (int i = 0; i < 1000; i++) begin
      step(1'b0, 8'h00);
      if (w_obs !== exp_vec()) begin
        n_err++; $display("FAIL mid_clear %0d: got %h want %h", i, w_obs, exp_vec());
      end
      n_vec++;
    end
    reset = 1'b1;
    model_reset();
    #1;
    if (w_obs !== exp_vec() || buf_we !== 1'b0) begin
      n_err++; $display("FAIL abort_reset: got %h want %h", w_obs, exp_vec());
    end
    n_vec++;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < CELLS; i++) begin
      step(1'b1, rand_char());
      if (w_obs !== exp_vec()) begin
        n_err++; $display("FAIL restart_clear %0d: got %h want %h", i, w_obs, exp_vec());
      end
      n_vec++;
    end
    if ({char_ready, busy, cursor_col, cursor_row} !== {1'b1, 1'b0, 7'd0, 5'd0}) begin
      n_err++; $display("FAIL restart_done: got ready=%b busy=%b", char_ready, busy);
    end
    n_vec++;
  endtask

  initial begin
    test_reset();
    test_print_one();
    test_back_to_back();
    test_backspace();
    test_row_limit();
    test_random();
    test_reset_mid_clear();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vga_console_ctrl.md
VGA_CONSOLE_CTRL -- requirements
Module: vga_console_ctrl

Interface
REQ-001 SHALL have parameter COLS, default 80, text columns per row.
REQ-002 SHALL have parameter ROWS, default 30, text rows per screen.
REQ-003 SHALL have parameter ADDR_WIDTH, default 12, text-buffer address width; ADDR_WIDTH SHALL be at least clog2(COLS*ROWS).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state SHALL be on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port char_valid, input, 1 bit: the producer offers char_data.
REQ-007 SHALL have port char_data, input, 8 bits: ASCII code.
REQ-008 SHALL have port char_ready, output, 1 bit: the block accepts char_data this cycle.
REQ-009 SHALL have port buf_addr, output, ADDR_WIDTH bits: text-buffer write address, driving DATA_ADDR.
REQ-010 SHALL have port buf_data, output, 8 bits: text-buffer write data, driving DATA_IN.
REQ-011 SHALL have port buf_we, output, 1 bit: text-buffer write enable, driving WR_EN.
REQ-012 SHALL have port cursor_col, output, clog2(COLS) bits: current cursor column.
REQ-013 SHALL have port cursor_row, output, clog2(ROWS) bits: current cursor row.
REQ-014 SHALL have port busy, output, 1 bit: high while the screen clear is in progress.

Function
REQ-015 SHALL implement exactly two states: IDLE and CLEAR.
REQ-016 SHALL drive char_ready = (state==IDLE) and busy = (state==CLEAR).
REQ-017 SHALL accept a character when char_valid && char_ready; in IDLE it SHALL accept one character per cycle with no bubbles.
REQ-018 Cell address SHALL be cursor_row*COLS + cursor_col, zero-extended to ADDR_WIDTH.
REQ-019 Printable character (0x20-0x7E): on the accept edge the block SHALL register buf_we=1, buf_addr=old cursor address and buf_data=char_data, then advance the cursor; write latency is 1 cycle.
REQ-020 Cursor advance: col+1; when col==COLS-1, col SHALL become 0 and the row SHALL advance (REQ-027).
REQ-021 0x0A (LF) SHALL set col=0 and advance the row, with no write.
REQ-022 0x0D (CR) SHALL set col=0, with no write.
REQ-023 0x08 (BS) with col>0 SHALL set col=col-1 and write 0x20 at the new address; with col==0 it SHALL do nothing.
REQ-024 0x0C (FF) SHALL enter CLEAR and issue no write on the accept cycle.
REQ-025 Any other code (0x00-0x1F not listed above, 0x7F-0xFF) SHALL be consumed with no write and no cursor change.
REQ-026 In CLEAR, a counter SHALL run from 0 to COLS*ROWS-1, one write per cycle (buf_we=1, buf_addr=counter, buf_data=0x20). After the last write, state SHALL go to IDLE and the cursor SHALL be set to (0,0).
REQ-027 Row advance at row<ROWS-1 SHALL give row+1; at ROWS-1 the result depends on CONSOLE_WRAP_EN (REQ-032).
REQ-028 buf_we SHALL be low in any cycle not following a write-producing accept or a CLEAR step; buf_addr and buf_data SHALL hold their last values when buf_we is low.

Reset
REQ-029 While reset is asserted: buf_we=0, buf_addr=0, buf_data=0, cursor=(0,0), counter=0, state=CLEAR (busy=1, char_ready=0).
REQ-030 After reset release, a full clear SHALL run starting at address 0.
REQ-031 Reset asserted mid-clear or mid-stream SHALL abort immediately; the clear SHALL restart from address 0 after release.

Configuration
REQ-032 Macro CONSOLE_WRAP_EN: when defined, a row advance at ROWS-1 SHALL wrap to row 0; when undefined, the row SHALL saturate at ROWS-1, and further text overwrites the last row. Column behaviour SHALL be identical in both builds.

Verification (COLS=80, ROWS=30)
REQ-033 Release reset: expect 2400 consecutive buf_we pulses, addr 0..2399, data 0x20, char_ready=0; then char_ready=1 and cursor (0,0).
REQ-034 Send 0x41: expect buf_we=1, addr 0, data 0x41 one cycle later; cursor_col=1.
REQ-035 Send 80 back-to-back 0x58: expect addrs 0..79 on consecutive cycles; final cursor (0,1).
REQ-036 Send BS at col 0: expect no write. Send "AB" then BS: expect a write of 0x20 at addr 1 and cursor_col=1.
REQ-037 Cursor at row 29, send LF: expect row 0 with CONSOLE_WRAP_EN, row 29 without; col 0 in both.
REQ-038 Send FF, assert reset at counter 1000: expect buf_we=0 immediately; after release, the clear restarts at addr 0 and completes 2400 writes.
